// File: rtl/mem_access_unit_if.sv
// Request/acknowledge data-memory bus between the MEM-stage load/store engine and data memory.
// The master side holds a request stable until ack. The slave returns rdata in the same cycle as ack.
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine with byte-lane alignment and bus request FSM; optional bus timeout under DMEM_TIMEOUT_EN.
// Latency: registered request one cycle after detect; load word on ReadDataM one cycle after ack (min 2-cycle stall).
// Backpressure: stallM holds IF..MEM while busy; holdM parks the FSM in DONE with outputs held.
module mem_access_unit #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              instrM,
  input  logic [31:0]              ALUOutM,
  input  logic [31:0]              WriteDataM,
  input  logic                     holdM,
  mem_access_unit_if.master        dmem,
  output logic [31:0]              ReadDataM,
  output logic [1:0]               MemAddrM,
  output logic                     stallM,
  output logic                     misalignM,
  output logic                     buserrM
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } busReqT;

  stateT  state, stateNext;
  logic   memOp, isStore, accHalf, accWord, misaligned;
  logic   startAcc, timeoutHit;
  busReqT reqNext;

  logic [5:0] opcode;
  assign opcode = instrM[31:26];

  always_comb begin
    memOp   = 1'b0;
    isStore = 1'b0;
    accHalf = 1'b0;
    accWord = 1'b0;
    case (opcode)
      6'h20, 6'h24: memOp = 1'b1;
      6'h21, 6'h25: begin memOp = 1'b1; accHalf = 1'b1; end
      6'h23:        begin memOp = 1'b1; accWord = 1'b1; end
      6'h28:        begin memOp = 1'b1; isStore = 1'b1; end
      6'h29:        begin memOp = 1'b1; isStore = 1'b1; accHalf = 1'b1; end
      6'h2B:        begin memOp = 1'b1; isStore = 1'b1; accWord = 1'b1; end
      default:      memOp = 1'b0;
    endcase
  end

  assign misaligned = (accHalf & ALUOutM[0]) | (accWord & (|ALUOutM[1:0]));
  assign misalignM  = memOp & misaligned & (state == IDLE);

  // Little-endian lane placement; stores replicate data so the selected lanes carry it.
  always_comb begin
    reqNext.we    = isStore;
    reqNext.be    = 4'b1111;
    reqNext.addr  = {ALUOutM[31:2], 2'b00};
    reqNext.wdata = 32'h0;
    if (isStore) begin
      if (accWord) begin
        reqNext.wdata = WriteDataM;
      end else if (accHalf) begin
        reqNext.be    = ALUOutM[1] ? 4'b1100 : 4'b0011;
        reqNext.wdata = {2{WriteDataM[15:0]}};
      end else begin
        reqNext.be    = 4'b0001 << ALUOutM[1:0];
        reqNext.wdata = {4{WriteDataM[7:0]}};
      end
    end
  end

`ifdef DMEM_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] toCnt;
  assign timeoutHit = ~dmem.dmem_ack && (toCnt == CntW'(TIMEOUT_CYCLES - 1));
`else
  logic unusedCfg;
  assign unusedCfg  = ^{ERR_DATA, TIMEOUT_CYCLES};
  assign timeoutHit = 1'b0;
  assign buserrM    = 1'b0;
`endif

  logic unusedInstr;
  assign unusedInstr = ^instrM[25:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    stallM    = 1'b0;
    startAcc  = 1'b0;
    case (state)
      IDLE: begin
        if (memOp && !misaligned) begin
          stallM    = 1'b1;
          startAcc  = 1'b1;
          stateNext = BUSY;
        end
      end
      BUSY: begin
        stallM = 1'b1;
        if (dmem.dmem_ack || timeoutHit) stateNext = DONE;
      end
      DONE: begin
        if (!holdM) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_be    <= 4'b0;
      dmem.dmem_addr  <= 32'h0;
      dmem.dmem_wdata <= 32'h0;
      ReadDataM       <= 32'h0;
      MemAddrM        <= 2'b0;
`ifdef DMEM_TIMEOUT_EN
      toCnt           <= '0;
      buserrM         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (startAcc) begin
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= reqNext.we;
            dmem.dmem_be    <= reqNext.be;
            dmem.dmem_addr  <= reqNext.addr;
            dmem.dmem_wdata <= reqNext.wdata;
            MemAddrM        <= ALUOutM[1:0];
`ifdef DMEM_TIMEOUT_EN
            toCnt           <= '0;
`endif
          end
        end
        BUSY: begin
          if (dmem.dmem_ack) begin
            dmem.dmem_req <= 1'b0;
            ReadDataM     <= dmem.dmem_we ? 32'h0 : dmem.dmem_rdata;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (timeoutHit) begin
            dmem.dmem_req <= 1'b0;
            ReadDataM     <= ERR_DATA;
            buserrM       <= 1'b1;
          end else begin
            toCnt <= toCnt + 1'b1;
          end
`endif
        end
        DONE: begin
`ifdef DMEM_TIMEOUT_EN
          if (!holdM) buserrM <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalignment, hold in DONE, mid-transaction reset, optional timeout.
module tb_mem_access_unit;
  logic        clk;
  logic        rst;
  logic [31:0] instrM, ALUOutM, WriteDataM;
  logic        holdM;
  logic [31:0] ReadDataM;
  logic [1:0]  MemAddrM;
  logic        stallM, misalignM, buserrM;
  int          checks;
  int          failures;

  localparam logic [31:0] OP_LW  = 32'h8C00_0000;
  localparam logic [31:0] OP_LBU = 32'h9000_0000;
  localparam logic [31:0] OP_LH  = 32'h8400_0000;
  localparam logic [31:0] OP_SB  = 32'hA000_0000;
  localparam logic [31:0] OP_SH  = 32'hA400_0000;
  localparam logic [31:0] OP_SW  = 32'hAC00_0000;
  localparam logic [31:0] OP_ADD = 32'h0000_0020;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT_CYCLES(4), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk        (clk),
    .rst        (rst),
    .instrM     (instrM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .holdM      (holdM),
    .dmem       (bus.master),
    .ReadDataM  (ReadDataM),
    .MemAddrM   (MemAddrM),
    .stallM     (stallM),
    .misalignM  (misalignM),
    .buserrM    (buserrM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; instrM = 32'h0; ALUOutM = 32'h0; WriteDataM = 32'h0; holdM = 1'b0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
    tick(); tick();
    rst = 1'b0;
    settle();
    chk("rst_req", {31'b0, bus.dmem_req}, 32'h0);
    chk("rst_rdata", ReadDataM, 32'h0);
    chk("rst_maddr", {30'b0, MemAddrM}, 32'h0);
    chk("rst_stall", {31'b0, stallM}, 32'h0);
    chk("rst_buserr", {31'b0, buserrM}, 32'h0);
    chk("rst_be", {28'b0, bus.dmem_be}, 32'h0);

    // non-memory op does nothing
    instrM = OP_ADD; ALUOutM = 32'h0000_1006; settle();
    chk("alu_stall", {31'b0, stallM}, 32'h0);
    chk("alu_misal", {31'b0, misalignM}, 32'h0);

    // lw 0x1004, ack on first BUSY cycle
    instrM = OP_LW; ALUOutM = 32'h0000_1004; settle();
    chk("lw_detect_stall", {31'b0, stallM}, 32'h1);
    tick();
    chk("lw_req", {31'b0, bus.dmem_req}, 32'h1);
    chk("lw_addr", bus.dmem_addr, 32'h0000_1004);
    chk("lw_be", {28'b0, bus.dmem_be}, 32'hF);
    chk("lw_we", {31'b0, bus.dmem_we}, 32'h0);
    chk("lw_busy_stall", {31'b0, stallM}, 32'h1);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h1234_5678;
    tick();
    bus.dmem_ack = 1'b0;
    chk("lw_done_stall", {31'b0, stallM}, 32'h0);
    chk("lw_done_req", {31'b0, bus.dmem_req}, 32'h0);
    chk("lw_rdata", ReadDataM, 32'h1234_5678);
    chk("lw_maddr", {30'b0, MemAddrM}, 32'h0);
    chk("lw_buserr", {31'b0, buserrM}, 32'h0);
    instrM = 32'h0;
    tick();
    chk("idle_hold_rdata", ReadDataM, 32'h1234_5678);
    chk("idle_stall", {31'b0, stallM}, 32'h0);

    // sb 0x2003, ack on third BUSY cycle
    instrM = OP_SB; ALUOutM = 32'h0000_2003; WriteDataM = 32'h0000_00AB; settle();
    chk("sb_detect_stall", {31'b0, stallM}, 32'h1);
    tick();
    chk("sb_be", {28'b0, bus.dmem_be}, 32'h8);
    chk("sb_wdata", bus.dmem_wdata, 32'hABAB_ABAB);
    chk("sb_we", {31'b0, bus.dmem_we}, 32'h1);
    chk("sb_addr", bus.dmem_addr, 32'h0000_2000);
    tick();
    chk("sb_busy2_stall", {31'b0, stallM}, 32'h1);
    chk("sb_busy2_req", {31'b0, bus.dmem_req}, 32'h1);
    tick();
    chk("sb_busy3_stall", {31'b0, stallM}, 32'h1);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hFFFF_FFFF;
    tick();
    bus.dmem_ack = 1'b0;
    chk("sb_done_stall", {31'b0, stallM}, 32'h0);
    chk("sb_rdata_zero", ReadDataM, 32'h0);
    chk("sb_maddr", {30'b0, MemAddrM}, 32'h3);
    instrM = 32'h0;
    tick();

    // sh 0x2002
    instrM = OP_SH; ALUOutM = 32'h0000_2002; WriteDataM = 32'h0000_BEEF;
    tick();
    chk("sh_be", {28'b0, bus.dmem_be}, 32'hC);
    chk("sh_wdata", bus.dmem_wdata, 32'hBEEF_BEEF);
    bus.dmem_ack = 1'b1;
    tick();
    bus.dmem_ack = 1'b0;
    chk("sh_maddr", {30'b0, MemAddrM}, 32'h2);
    instrM = 32'h0;
    tick();

    // misaligned lh and sw: no stall, no request
    instrM = OP_LH; ALUOutM = 32'h0000_2001; settle();
    chk("lh_misal", {31'b0, misalignM}, 32'h1);
    chk("lh_stall", {31'b0, stallM}, 32'h0);
    tick();
    chk("lh_noreq", {31'b0, bus.dmem_req}, 32'h0);
    instrM = OP_SW; ALUOutM = 32'h0000_2002; settle();
    chk("sw_misal", {31'b0, misalignM}, 32'h1);
    tick();
    chk("sw_noreq", {31'b0, bus.dmem_req}, 32'h0);

    // lbu at odd address is legal
    instrM = OP_LBU; ALUOutM = 32'h0000_1001; settle();
    chk("lbu_misal", {31'b0, misalignM}, 32'h0);
    tick();
    chk("lbu_be", {28'b0, bus.dmem_be}, 32'hF);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h00C3_0000;
    tick();
    bus.dmem_ack = 1'b0;
    chk("lbu_maddr", {30'b0, MemAddrM}, 32'h1);
    chk("lbu_rdata", ReadDataM, 32'h00C3_0000);
    instrM = 32'h0;
    tick();

    // lw completes under holdM; stray ack in DONE ignored
    instrM = OP_LW; ALUOutM = 32'h0000_3008;
    tick();
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hCAFE_F00D;
    tick();
    holdM = 1'b1; bus.dmem_ack = 1'b0;
    chk("hold_rdata0", ReadDataM, 32'hCAFE_F00D);
    tick();
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h1111_1111;
    settle();
    chk("hold_stall1", {31'b0, stallM}, 32'h0);
    tick();
    bus.dmem_ack = 1'b0;
    chk("hold_rdata2", ReadDataM, 32'hCAFE_F00D);
    chk("hold_stall2", {31'b0, stallM}, 32'h0);
    chk("hold_req2", {31'b0, bus.dmem_req}, 32'h0);
    holdM = 1'b0; instrM = 32'h0;
    tick();
    chk("hold_exit_stall", {31'b0, stallM}, 32'h0);
    chk("hold_exit_rdata", ReadDataM, 32'hCAFE_F00D);

    // reset on second BUSY cycle
    instrM = OP_LW; ALUOutM = 32'h0000_4000;
    tick();
    tick();
    chk("rstmid_req", {31'b0, bus.dmem_req}, 32'h1);
    chk("rstmid_stall", {31'b0, stallM}, 32'h1);
    rst = 1'b1; instrM = 32'h0;
    tick();
    rst = 1'b0;
    chk("rstmid_req_after", {31'b0, bus.dmem_req}, 32'h0);
    chk("rstmid_rdata", ReadDataM, 32'h0);
    chk("rstmid_stall_after", {31'b0, stallM}, 32'h0);
    chk("rstmid_addr", bus.dmem_addr, 32'h0);
    instrM = OP_LW; ALUOutM = 32'h0000_5004;
    tick();
    chk("post_rst_addr", bus.dmem_addr, 32'h0000_5004);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h0BAD_F00D;
    tick();
    bus.dmem_ack = 1'b0;
    chk("post_rst_rdata", ReadDataM, 32'h0BAD_F00D);
    chk("post_rst_stall", {31'b0, stallM}, 32'h0);
    instrM = 32'h0;
    tick();

`ifdef DMEM_TIMEOUT_EN
    // no ack: times out after four BUSY cycles
    instrM = OP_LW; ALUOutM = 32'h0000_6000;
    tick();
    tick(); tick(); tick();
    chk("to_busy4_req", {31'b0, bus.dmem_req}, 32'h1);
    chk("to_busy4_buserr", {31'b0, buserrM}, 32'h0);
    tick();
    chk("to_req", {31'b0, bus.dmem_req}, 32'h0);
    chk("to_rdata", ReadDataM, 32'hDEAD_BEEF);
    chk("to_buserr", {31'b0, buserrM}, 32'h1);
    chk("to_stall", {31'b0, stallM}, 32'h0);
    instrM = 32'h0;
    tick();
    chk("to_buserr_clr", {31'b0, buserrM}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage load/store engine in the 5-stage MIPS datapath. It sits between the EX/MEM pipeline register and mem_wb, and drives a request/acknowledge data-memory bus.
- Stores: aligns store data into byte lanes and generates byte enables.
- Loads: fetches the raw aligned word.
- Both: stalls the pipeline for the duration of the bus transaction.
- Outputs: raw word (ReadDataM) and byte offset (MemAddrM), which mem_wb registers so writeback can extract and extend loads.

Parameters:
TIMEOUT_CYCLES, 64, ack wait limit in BUSY before a bus error (used only with DMEM_TIMEOUT_EN).
ERR_DATA, 32'hDEADBEEF, value returned on ReadDataM after a timed-out access.

Ports:
clk  input  1  pipeline clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
instrM  input  32  instruction in MEM stage; opcode = instrM[31:26].
ALUOutM  input  32  effective byte address.
WriteDataM  input  32  store source register value.
holdM  input  1  external pipeline hold (downstream/hazard stall).
dmem_req  output  1  bus request; registered.
dmem_we  output  1  1 = write; registered.
dmem_be  output  4  byte enables, bit i = byte lane i (bits 8i+7:8i); registered.
dmem_addr  output  32  word address {addr[31:2],2'b00}; registered.
dmem_wdata  output  32  lane-replicated store data; registered.
dmem_ack  input  1  access complete; rdata valid same cycle.
dmem_rdata  input  32  read word.
ReadDataM  output  32  captured read word to mem_wb.
MemAddrM  output  2  captured addr[1:0] to mem_wb.
stallM  output  1  hold IF..MEM stages.
misalignM  output  1  address exception (AdEL/AdES), combinational.
buserrM  output  1  timeout flag, valid in DONE (tied 0 without feature).

Behaviour:
- Opcode decode:
  - Loads: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25.
  - Stores: sb 0x28, sh 0x29, sw 0x2B.
  - Anything else: mem_op = 0.
- Misalignment:
  - lh/lhu/sh with addr[0] = 1; lw/sw with addr[1:0] != 0.
  - misalignM = mem_op & misaligned while in IDLE.
  - A misaligned op starts no bus access and does not raise stallM.
- Byte lanes (little-endian):
  - sb: be = 1 << addr[1:0]; wdata = {4{WD[7:0]}}.
  - sh: be = addr[1] ? 1100 : 0011; wdata = {2{WD[15:0]}}.
  - sw: be = 1111; wdata = WD.
  - Loads: be = 1111, we = 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - stallM = mem_op & ~misaligned (combinational).
  - If so: latch addr/we/be/wdata and MemAddrM <= addr[1:0]; dmem_req <= 1; go BUSY.
- BUSY:
  - stallM = 1; dmem_req held high; all bus outputs stable.
  - On posedge with dmem_ack = 1: ReadDataM <= dmem_rdata (stores: ReadDataM <= 0); dmem_req <= 0; go DONE.
  - Ack may arrive on the first BUSY cycle (one-cycle memory gives 2-cycle total MEM occupancy).
- DONE:
  - stallM = 0, so the pipeline advances and mem_wb captures ReadDataM/MemAddrM.
  - If holdM = 1: stay in DONE, outputs held.
  - Else: go IDLE.
- dmem_ack outside BUSY is ignored.
- ReadDataM and MemAddrM hold their last value in IDLE.
- Latency: load data visible at ReadDataM one cycle after ack; min stall = 2 cycles (IDLE-detect cycle + BUSY).
- Reset (synchronous, may occur mid-transaction):
  - state = IDLE.
  - dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, ReadDataM, MemAddrM, buserrM = 0.
  - An outstanding request is abandoned; the memory must tolerate req dropping.
- Back-to-back memory ops: DONE→IDLE→BUSY; no combinational path from dmem_ack to dmem_req.

Optional Feature:
DMEM_TIMEOUT_EN:
- Defined:
  - Counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES: dmem_req <= 0, ReadDataM <= ERR_DATA, buserrM <= 1, go DONE.
  - buserrM clears on leaving DONE.
  - Ack on the same cycle as the limit wins (normal completion).
- Undefined: no counter; BUSY waits indefinitely; buserrM tied 0.

Test Plan:
- lw at 0x0000_1004, ack on 1st BUSY cycle, rdata 0x1234_5678 → dmem_addr 0x1004, be 1111, we 0; stallM high 2 cycles; ReadDataM 0x1234_5678, MemAddrM 00 in DONE.
- sb at 0x0000_2003, WriteDataM 0x0000_00AB, ack after 3 cycles → be 1000, wdata 0xABAB_ABAB, we 1; stallM high 4 cycles.
- sh at 0x0000_2002, WD 0x0000_BEEF → be 1100, wdata 0xBEEF_BEEF; lh at 0x0000_2001 → misalignM = 1, dmem_req never asserted, stallM = 0.
- lw completes with holdM = 1 for 3 cycles in DONE → state and ReadDataM held; a stray dmem_ack during DONE has no effect; return to IDLE when holdM drops.
- rst asserted on 2nd BUSY cycle → next edge: dmem_req = 0, ReadDataM = 0, stallM = 0; a following lw completes normally.
- DMEM_TIMEOUT_EN with TIMEOUT_CYCLES = 4, no ack → req drops after 4 BUSY cycles, ReadDataM = 0xDEADBEEF, buserrM = 1 for the DONE cycle.
